// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared widths, ALU opcodes, operand record and sign-extension helper
package operand_fetch_stage_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int IMM_W = 16;
  localparam int NREG = 2**ADDR_W;
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0] ctr;
    logic [ADDR_W-1:0] rd;
    logic rd_we;
  } op_t;
  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] x);
    return {{(DATA_W-IMM_W){x[IMM_W-1]}}, x};
  endfunction
endpackage

// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: request, operand, writeback and scoreboard bundle
interface operand_fetch_stage_if;
  import operand_fetch_stage_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic rd_we;
  logic [IMM_W-1:0] imm;
  logic use_imm;
  logic [2:0] alu_ctr_in;
  logic op_valid;
  logic op_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [2:0] ALU_Ctr;
  logic [ADDR_W-1:0] op_rd;
  logic op_rd_we;
  logic wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [NREG-1:0] busy;
  modport master (
    output req_valid, rs, rt, rd, rd_we, imm, use_imm, alu_ctr_in, op_ready, wb_we, wb_addr, wb_data,
    input req_ready, op_valid, A, B, ALU_Ctr, op_rd, op_rd_we, busy
  );
  modport slave (
    input req_valid, rs, rt, rd, rd_we, imm, use_imm, alu_ctr_in, op_ready, wb_we, wb_addr, wb_data,
    output req_ready, op_valid, A, B, ALU_Ctr, op_rd, op_rd_we, busy
  );
endinterface

// File: rtl/operand_fetch_stage_regfile_2r1w.sv
// regfile_2r1w: two async read ports with write bypass, one sync write port, r0 hardwired to zero
module regfile_2r1w
  import operand_fetch_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic we,
  input logic [ADDR_W-1:0] waddr,
  input logic [DATA_W-1:0] wdata,
  input logic [ADDR_W-1:0] ra,
  input logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
    rdata_a = ra == '0 ? '0 : (we && waddr == ra) ? wdata : mem_q[ra];
    rdata_b = rb == '0 ? '0 : (we && waddr == rb) ? wdata : mem_q[rb];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '0;
    else mem_q <= mem_d;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register read, bypass, busy scoreboard and registered operand handoff to the ALU
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  operand_fetch_stage_if.slave bus
);
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [NREG-1:0] busy_q, busy_d, eff_busy;
  logic op_valid_q, op_valid_d, hazard, ready, accept;
  op_t op_q, op_d;
  regfile_2r1w u_rf (
    .clk(clk),
    .rst(rst),
    .we(bus.wb_we),
    .waddr(bus.wb_addr),
    .wdata(bus.wb_data),
    .ra(bus.rs),
    .rb(bus.rt),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b)
  );
  always_comb begin
    eff_busy = busy_q & ~(bus.wb_we ? NREG'(1) << bus.wb_addr : '0);
    hazard = bus.req_valid & (eff_busy[bus.rs] | (~bus.use_imm & eff_busy[bus.rt]) | (bus.rd_we & eff_busy[bus.rd]));
    ready = (~op_valid_q | bus.op_ready) & ~hazard;
    accept = bus.req_valid & ready;
    busy_d = eff_busy | (accept & bus.rd_we & (bus.rd != '0) ? NREG'(1) << bus.rd : '0);
    op_valid_d = accept | (op_valid_q & ~bus.op_ready);
    op_d = accept ? op_t'{a: rdata_a, b: bus.use_imm ? sext(bus.imm) : rdata_b, ctr: bus.alu_ctr_in, rd: bus.rd, rd_we: bus.rd_we} : op_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q <= '0;
      op_valid_q <= 1'b0;
      op_q <= '0;
    end else begin
      busy_q <= busy_d;
      op_valid_q <= op_valid_d;
      op_q <= op_d;
    end
  assign bus.req_ready = ready;
  assign bus.op_valid = op_valid_q;
  assign bus.A = op_q.a;
  assign bus.B = op_q.b;
  assign bus.ALU_Ctr = op_q.ctr;
  assign bus.op_rd = op_q.rd;
  assign bus.op_rd_we = op_q.rd_we;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: table-driven, scoreboard-checked bench for operand_fetch_stage
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;
  typedef struct packed {
    logic v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic we;
    logic [15:0] imm;
    logic ui;
    logic [2:0] ctr;
    logic ordy;
    logic wwe;
    logic [4:0] wa;
    logic [31:0] wd;
    logic rdy;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] regs [32];
  logic [31:0] mbusy;
  op_t q [$];
  vec_t vecs [19];
  operand_fetch_stage_if bus();
  operand_fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic we, logic [15:0] imm, logic ui, logic [2:0] ctr, logic ordy, logic wwe, logic [4:0] wa, logic [31:0] wd, logic rdy);
    return '{v, rs, rt, rd, we, imm, ui, ctr, ordy, wwe, wa, wd, rdy};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag);
    chk({tag, " op_valid"}, 32'(bus.op_valid), 32'(q.size() != 0));
    chk({tag, " busy"}, bus.busy, mbusy);
    if (q.size() != 0) begin
      chk({tag, " A"}, bus.A, q[0].a);
      chk({tag, " B"}, bus.B, q[0].b);
      chk({tag, " ALU_Ctr"}, 32'(bus.ALU_Ctr), 32'(q[0].ctr));
      chk({tag, " op_rd"}, 32'(bus.op_rd), 32'(q[0].rd));
      chk({tag, " op_rd_we"}, 32'(bus.op_rd_we), 32'(q[0].rd_we));
    end
  endtask
  task automatic step(input vec_t t, input string tag);
    logic [31:0] a, b;
    logic acc;
    @(negedge clk);
    bus.req_valid = t.v;
    bus.rs = t.rs;
    bus.rt = t.rt;
    bus.rd = t.rd;
    bus.rd_we = t.we;
    bus.imm = t.imm;
    bus.use_imm = t.ui;
    bus.alu_ctr_in = t.ctr;
    bus.op_ready = t.ordy;
    bus.wb_we = t.wwe;
    bus.wb_addr = t.wa;
    bus.wb_data = t.wd;
    #1;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(t.rdy));
    acc = t.v & t.rdy;
    a = t.rs == 0 ? 32'h0 : (t.wwe && t.wa == t.rs) ? t.wd : regs[t.rs];
    b = t.ui ? {{16{t.imm[15]}}, t.imm} : t.rt == 0 ? 32'h0 : (t.wwe && t.wa == t.rt) ? t.wd : regs[t.rt];
    @(posedge clk);
    if (q.size() != 0 && t.ordy) void'(q.pop_front());
    if (acc) q.push_back(op_t'{a: a, b: b, ctr: t.ctr, rd: t.rd, rd_we: t.we});
    if (t.wwe) begin
      mbusy[t.wa] = 1'b0;
      if (t.wa != 0) regs[t.wa] = t.wd;
    end
    if (acc && t.we && t.rd != 0) mbusy[t.rd] = 1'b1;
    #1;
    chk_out(tag);
  endtask
  initial begin
    bus.req_valid = 0;
    bus.rs = 0;
    bus.rt = 0;
    bus.rd = 0;
    bus.rd_we = 0;
    bus.imm = 0;
    bus.use_imm = 0;
    bus.alu_ctr_in = 0;
    bus.op_ready = 0;
    bus.wb_we = 0;
    bus.wb_addr = 0;
    bus.wb_data = 0;
    mbusy = 0;
    foreach (regs[i]) regs[i] = 0;
    vecs[0] = mk(0, 0, 0, 0, 0, 16'h0, 0, 3'd0, 1, 1, 3, 32'h5, 1);
    vecs[1] = mk(1, 3, 0, 0, 0, 16'h0, 0, ALU_ADD, 1, 0, 0, 32'h0, 1);
    vecs[2] = mk(1, 1, 0, 0, 0, 16'hFFFE, 1, ALU_AND, 1, 0, 0, 32'h0, 1);
    vecs[3] = mk(1, 0, 0, 4, 1, 16'h0, 0, ALU_SUB, 1, 0, 0, 32'h0, 1);
    vecs[4] = mk(1, 4, 0, 0, 0, 16'h0, 0, ALU_ADD, 1, 0, 0, 32'h0, 0);
    vecs[5] = mk(1, 4, 0, 0, 0, 16'h0, 0, ALU_ADD, 1, 0, 0, 32'h0, 0);
    vecs[6] = mk(1, 4, 0, 0, 0, 16'h0, 0, ALU_ADD, 1, 1, 4, 32'h1234, 1);
    vecs[7] = mk(1, 3, 4, 0, 0, 16'h0, 0, ALU_SLT, 0, 0, 0, 32'h0, 0);
    vecs[8] = mk(1, 3, 4, 0, 0, 16'h0, 0, ALU_SLT, 0, 0, 0, 32'h0, 0);
    vecs[9] = mk(1, 3, 4, 0, 0, 16'h0, 0, ALU_SLT, 0, 0, 0, 32'h0, 0);
    vecs[10] = mk(1, 3, 4, 0, 0, 16'h0, 0, ALU_SLT, 1, 0, 0, 32'h0, 1);
    vecs[11] = mk(1, 0, 0, 0, 1, 16'h0, 0, ALU_OR, 1, 1, 0, 32'hDEADBEEF, 1);
    vecs[12] = mk(1, 0, 0, 5, 1, 16'h0, 0, ALU_ADD, 1, 0, 0, 32'h0, 1);
    vecs[13] = mk(1, 0, 0, 5, 1, 16'h0, 0, ALU_ADD, 1, 1, 5, 32'h77, 1);
    vecs[14] = mk(1, 0, 0, 5, 1, 16'h0, 0, ALU_ADD, 1, 0, 0, 32'h0, 0);
    vecs[15] = mk(1, 5, 0, 0, 0, 16'h7FFF, 1, ALU_AND, 0, 0, 0, 32'h0, 0);
    vecs[16] = mk(1, 0, 5, 0, 0, 16'h8000, 1, ALU_SUB, 1, 0, 0, 32'h0, 1);
    vecs[17] = mk(1, 3, 0, 0, 0, 16'h0, 0, ALU_ADD, 0, 0, 0, 32'h0, 0);
    vecs[18] = mk(1, 3, 5, 0, 0, 16'h0, 0, ALU_ADD, 1, 0, 0, 32'h0, 1);
    #2;
    chk_out("reset");
    chk("reset A", bus.A, 32'h0);
    chk("reset B", bus.B, 32'h0);
    chk("reset ALU_Ctr", 32'(bus.ALU_Ctr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) step(vecs[i], $sformatf("v%0d", i));
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    mbusy = 0;
    foreach (regs[i]) regs[i] = 0;
    chk_out("rst_mid");
    chk("rst_mid A", bus.A, 32'h0);
    chk("rst_mid op_rd", 32'(bus.op_rd), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    step(vecs[18], "after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
